// File: rtl/instr_cache_pkg.sv
// Shared defaults and FSM encoding for the direct-mapped instruction cache.
package instr_cache_pkg;

  localparam int unsigned ADDR_W_DEF   = 10;
  localparam int unsigned INDEX_W_DEF  = 3;
  localparam int unsigned OFFSET_W_DEF = 4;
  localparam int unsigned WORD_W       = 32;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MEM_READ = 1'b1
  } state_e;

endpackage

// File: rtl/icache_store.sv
// Valid/tag/data arrays: async-cleared valid bits, registered line fill,
// combinational word read and tag compare.
module icache_store
  import instr_cache_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned INDEX_W  = INDEX_W_DEF,
  parameter int unsigned OFFSET_W = OFFSET_W_DEF,
  localparam int unsigned TAG_W   = ADDR_W - INDEX_W - OFFSET_W,
  localparam int unsigned BLOCK_W = 8 << OFFSET_W,
  localparam int unsigned WSEL_W  = OFFSET_W - 2,
  localparam int unsigned LINES   = 1 << INDEX_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rd_en,
  input  logic [TAG_W-1:0]   rd_tag,
  input  logic [INDEX_W-1:0] rd_index,
  input  logic [WSEL_W-1:0]  rd_word,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [BLOCK_W-1:0] wr_data,
  output logic               hit_c,
  output logic [WORD_W-1:0]  rd_data_c
);

  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [BLOCK_W-1:0] data_mem [LINES];
  logic [BLOCK_W-1:0] line_c;

  // Only the valid bits are reset; stale tag/data are masked by valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_data;
    end
  end

  assign line_c    = data_mem[rd_index];
  assign hit_c     = rd_en & valid_q[rd_index] & (tag_mem[rd_index] == rd_tag);
  assign rd_data_c = hit_c ? line_c[{rd_word, 5'd0} +: WORD_W] : '0;

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache; stalls the fetch port on a miss
// and refills the whole line from block memory.
module instr_cache
  import instr_cache_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned INDEX_W  = INDEX_W_DEF,
  parameter int unsigned OFFSET_W = OFFSET_W_DEF,
  localparam int unsigned TAG_W   = ADDR_W - INDEX_W - OFFSET_W,
  localparam int unsigned BLOCK_W = 8 << OFFSET_W,
  localparam int unsigned MADDR_W = ADDR_W - OFFSET_W,
  localparam int unsigned WSEL_W  = OFFSET_W - 2
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [ADDR_W-1:0]  ADDRESS,
  input  logic               READ,
  output logic [WORD_W-1:0]  READDATA,
  output logic               BUSYWAIT,
  output logic [MADDR_W-1:0] MEM_ADDRESS,
  output logic               MEM_READ,
  input  logic [BLOCK_W-1:0] MEM_READDATA,
  input  logic               MEM_BUSYWAIT
);

  state_e             state_q, state_d;
  logic               hit_c;
  logic               fill_c;
  logic               capture_c;
  logic               unused_c;
  logic [TAG_W-1:0]   tag_c;
  logic [INDEX_W-1:0] index_c;
  logic [WSEL_W-1:0]  word_c;

  assign tag_c    = ADDRESS[ADDR_W-1 -: TAG_W];
  assign index_c  = ADDRESS[OFFSET_W +: INDEX_W];
  assign word_c   = ADDRESS[2 +: WSEL_W];
  assign unused_c = ^ADDRESS[1:0];

  icache_store #(
    .ADDR_W   (ADDR_W),
    .INDEX_W  (INDEX_W),
    .OFFSET_W (OFFSET_W)
  ) u_store (
    .clk       (CLK),
    .rst_n     (RESET),
    .rd_en     (READ),
    .rd_tag    (tag_c),
    .rd_index  (index_c),
    .rd_word   (word_c),
    .wr_en     (fill_c),
    .wr_index  (MEM_ADDRESS[INDEX_W-1:0]),
    .wr_tag    (MEM_ADDRESS[MADDR_W-1 -: TAG_W]),
    .wr_data   (MEM_READDATA),
    .hit_c     (hit_c),
    .rd_data_c (READDATA)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (READ && !hit_c) state_d = ST_MEM_READ;
      ST_MEM_READ: if (!MEM_BUSYWAIT)  state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    BUSYWAIT  = 1'b0;
    MEM_READ  = 1'b0;
    fill_c    = 1'b0;
    capture_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        BUSYWAIT  = READ & ~hit_c;
        capture_c = READ & ~hit_c;
      end
      ST_MEM_READ: begin
        BUSYWAIT = 1'b1;
        MEM_READ = 1'b1;
        fill_c   = ~MEM_BUSYWAIT;
      end
      default: ;
    endcase
  end

  // Block address is latched on the miss so the fill ignores later PC changes.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      MEM_ADDRESS <= '0;
    end else if (capture_c) begin
      MEM_ADDRESS <= {tag_c, index_c};
    end
  end

endmodule
